// File: rtl/vgm_wb_pkg.sv
// rtl/vgm_wb_pkg.sv - shared Wishbone slave types, widths and byte-lane merge helper
package vgm_wb_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_ADR_W  = 32;
   localparam int WB_SEL_W  = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } wb_state_e;

   function automatic logic [WB_DATA_W-1:0] lane_merge(
      input logic [WB_DATA_W-1:0] old_word,
      input logic [WB_DATA_W-1:0] new_word,
      input logic [WB_SEL_W-1:0]  sel
   );
      logic [WB_DATA_W-1:0] merged;
      merged = old_word;
      for (int i = 0; i < WB_SEL_W; i++) begin
         if (sel[i]) begin
            merged[8*i +: 8] = new_word[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/vgm_wb_reg_bank.sv
// rtl/vgm_wb_reg_bank.sv - register storage with byte-enable write and combinational read
module vgm_wb_reg_bank
   import vgm_wb_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int IDX_W    = 4
) (
   input  logic                 CLK_I,
   input  logic                 RST_I,
   input  logic                 wr_en,
   input  logic [IDX_W-1:0]     wr_idx,
   input  logic [WB_DATA_W-1:0] wr_data,
   input  logic [WB_SEL_W-1:0]  wr_sel,
   input  logic [IDX_W-1:0]     rd_idx,
   output logic [WB_DATA_W-1:0] rd_data
);

   logic [WB_DATA_W-1:0] regs [NUM_REGS];

   // The caller only raises wr_en for decoded-legal indices.
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[wr_idx] <= lane_merge(regs[wr_idx], wr_data, wr_sel);
      end
   end

   assign rd_data = regs[rd_idx];

endmodule

// File: rtl/vgm_wb_slave_regs.sv
// rtl/vgm_wb_slave_regs.sv - Wishbone B4 classic slave register bank with wait states and error response
module vgm_wb_slave_regs
   import vgm_wb_pkg::*;
#(
   parameter int          NUM_REGS    = 16,
   parameter int          WAIT_STATES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic                 CLK_I,
   input  logic                 RST_I,
   input  logic                 CYC_I,
   input  logic                 STB_I,
   input  logic                 WE_I,
   input  logic [WB_ADR_W-1:0]  ADR_I,
   input  logic [WB_DATA_W-1:0] DAT_I,
   input  logic [WB_SEL_W-1:0]  SEL_I,
   output logic [WB_DATA_W-1:0] DAT_O,
   output logic                 ACK_O,
   output logic                 ERR_O
);

   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

   wb_state_e              state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   req;
   logic [WB_ADR_W:0]      diff;
   logic                   legal_in;
   logic [IDX_W-1:0]       idx_in;
   logic                   legal_q, we_q;
   logic [IDX_W-1:0]       idx_q;
   logic [WB_DATA_W-1:0]   dat_q;
   logic [WB_SEL_W-1:0]    sel_q;
   logic                   from_idle;
   logic                   wr_we, wr_legal, wr_en;
   logic [IDX_W-1:0]       wr_idx;
   logic [WB_DATA_W-1:0]   wr_data;
   logic [WB_SEL_W-1:0]    wr_sel;
   logic [WB_DATA_W-1:0]   rd_data;

   assign req = CYC_I & STB_I;

   // Extra top bit is the borrow, set when ADR_I lies below BASE_ADDR.
   assign diff     = {1'b0, ADR_I} - {1'b0, BASE_ADDR};
   assign legal_in = !diff[WB_ADR_W] && (diff[1:0] == 2'b00)
                     && ({2'b00, diff[WB_ADR_W-1:2]} < 32'(NUM_REGS));
   assign idx_in   = diff[IDX_W+1:2];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (WAIT_STATES == 0) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(WAIT_STATES);
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (!req) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_W'(1)) begin
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         legal_q <= 1'b0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == IDLE && req) begin
            legal_q <= legal_in;
            we_q    <= WE_I;
            idx_q   <= idx_in;
            dat_q   <= DAT_I;
            sel_q   <= SEL_I;
         end
      end
   end

   // With zero wait states the commit edge is also the sample edge, so take the live bus fields.
   assign from_idle = (state_q == IDLE);
   assign wr_we     = from_idle ? WE_I     : we_q;
   assign wr_legal  = from_idle ? legal_in : legal_q;
   assign wr_idx    = from_idle ? idx_in   : idx_q;
   assign wr_data   = from_idle ? DAT_I    : dat_q;
   assign wr_sel    = from_idle ? SEL_I    : sel_q;
   assign wr_en     = (state_d == RESP) && (state_q != RESP) && wr_we && wr_legal;

   vgm_wb_reg_bank #(
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_bank (
      .CLK_I   (CLK_I),
      .RST_I   (RST_I),
      .wr_en   (wr_en),
      .wr_idx  (wr_idx),
      .wr_data (wr_data),
      .wr_sel  (wr_sel),
      .rd_idx  (idx_q),
      .rd_data (rd_data)
   );

   assign ACK_O = (state_q == RESP) && legal_q;
   assign ERR_O = (state_q == RESP) && !legal_q;
   assign DAT_O = (ACK_O && !we_q) ? rd_data : '0;

endmodule

// File: tb/tb_vgm_wb_slave_regs.sv
// tb/tb_vgm_wb_slave_regs.sv - directed self-checking bench for vgm_wb_slave_regs
module tb_vgm_wb_slave_regs;

   localparam int WS = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [31:0] adr = '0, wdat = '0, rdat;
   logic [3:0]  sel = '0;
   logic        ack, err;

   logic        cyc0 = 1'b0, stb0 = 1'b0, we0 = 1'b0;
   logic [31:0] adr0 = '0, wdat0 = '0, rdat0;
   logic [3:0]  sel0 = '0;
   logic        ack0, err0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   vgm_wb_slave_regs #(.NUM_REGS(16), .WAIT_STATES(WS), .BASE_ADDR(32'h0)) dut (
      .CLK_I(clk), .RST_I(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we),
      .ADR_I(adr), .DAT_I(wdat), .SEL_I(sel), .DAT_O(rdat), .ACK_O(ack), .ERR_O(err)
   );

   vgm_wb_slave_regs #(.NUM_REGS(16), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
      .CLK_I(clk), .RST_I(rst), .CYC_I(cyc0), .STB_I(stb0), .WE_I(we0),
      .ADR_I(adr0), .DAT_I(wdat0), .SEL_I(sel0), .DAT_O(rdat0), .ACK_O(ack0), .ERR_O(err0)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic xfer(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic exp_err, input logic [31:0] exp_d);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
      for (int k = 1; k <= WS; k++) begin
         @(negedge clk);
         chk({tag, ".hold"}, {30'd0, ack, err}, 32'd0);
      end
      @(negedge clk);
      chk({tag, ".ack"}, {31'd0, ack}, {31'd0, !exp_err});
      chk({tag, ".err"}, {31'd0, err}, {31'd0, exp_err});
      if (!w || exp_err) chk({tag, ".dat"}, rdat, exp_err ? 32'd0 : exp_d);
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      chk({tag, ".pulse"}, {30'd0, ack, err}, 32'd0);
   endtask

   task automatic set0(input int k);
      if (k > 7) begin
         cyc0 = 1'b0; stb0 = 1'b0;
      end else begin
         cyc0 = 1'b1; stb0 = 1'b1; sel0 = 4'hF;
         we0  = (k < 4);
         adr0 = 32'((k % 4) * 4);
         wdat0 = 32'hC0DE_0000 + 32'(k % 4);
      end
   endtask

   initial begin
      // reset held three cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst.out", {rdat[31:2], ack, err}, 32'd0);
      end
      rst = 1'b0;
      xfer("rd0", 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 32'h0);

      xfer("wr8", 1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
      xfer("rd8", 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF);

      xfer("wr4",  1'b1, 32'h4, 32'h1122_3344, 4'hF, 1'b0, 32'h0);
      xfer("wr4b", 1'b1, 32'h4, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h0);
      xfer("rd4b", 1'b0, 32'h4, 32'h0, 4'hF, 1'b0, 32'h11BB_33DD);
      xfer("wr4z", 1'b1, 32'h4, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0);
      xfer("rd4z", 1'b0, 32'h4, 32'h0, 4'hF, 1'b0, 32'h11BB_33DD);

      xfer("e40", 1'b0, 32'h40, 32'h0, 4'hF, 1'b1, 32'h0);
      xfer("e02", 1'b0, 32'h2, 32'h0, 4'hF, 1'b1, 32'h0);
      xfer("e44", 1'b1, 32'h44, 32'h5A5A_5A5A, 4'hF, 1'b1, 32'h0);
      xfer("e06", 1'b1, 32'h6, 32'h5A5A_5A5A, 4'hF, 1'b1, 32'h0);
      xfer("e.rd4", 1'b0, 32'h4, 32'h0, 4'hF, 1'b0, 32'h11BB_33DD);
      xfer("e.rd0", 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 32'h0);

      // abort in the first wait cycle
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'hC; wdat = 32'h1234_5678; sel = 4'hF;
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("abort.none", {30'd0, ack, err}, 32'd0);
      end
      xfer("abort.rdC", 1'b0, 32'hC, 32'h0, 4'hF, 1'b0, 32'h0);

      // bus fields changing mid-transfer must not matter
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h14; wdat = 32'h5555_AAAA; sel = 4'hF;
      @(negedge clk);
      adr = 32'h18; wdat = 32'hFFFF_FFFF; sel = 4'h3;
      @(negedge clk);
      chk("glitch.hold", {30'd0, ack, err}, 32'd0);
      @(negedge clk);
      chk("glitch.ack", {30'd0, ack, err}, 32'd2);
      cyc = 1'b0; stb = 1'b0;
      xfer("glitch.rd14", 1'b0, 32'h14, 32'h0, 4'hF, 1'b0, 32'h5555_AAAA);
      xfer("glitch.rd18", 1'b0, 32'h18, 32'h0, 4'hF, 1'b0, 32'h0);

      // async reset while ACK is high clears outputs at once
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h8; sel = 4'hF;
      for (int k = 0; k <= WS; k++) @(negedge clk);
      chk("rresp.pre", rdat, 32'hDEAD_BEEF);
      rst = 1'b1;
      #1;
      chk("rresp.ack", {30'd0, ack, err}, 32'd0);
      chk("rresp.dat", rdat, 32'd0);
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      xfer("rresp.rd8", 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, 32'h0);

      // reset during WAIT drops the write
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h10; wdat = 32'h0BAD_F00D; sel = 4'hF;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rwait.out", {30'd0, ack, err}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      cyc = 1'b0; stb = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rwait.none", {30'd0, ack, err}, 32'd0);
      end
      xfer("rwait.rd10", 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'h0);

      // zero wait states, STB held: writes regs 0..3 then reads them back
      @(negedge clk);
      set0(0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (i % 2 == 0) begin
            chk("ws0.ack", {30'd0, ack0, err0}, 32'd2);
            if (i / 2 >= 4) chk("ws0.dat", rdat0, 32'hC0DE_0000 + 32'(i / 2 - 4));
            set0(i / 2 + 1);
         end else begin
            chk("ws0.gap", {30'd0, ack0, err0}, 32'd0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vgm_wb_slave_regs.md
Name: vgm_wb_slave_regs

Overview:
Wishbone B4 classic-cycle slave: a bank of 32-bit read/write registers with a programmable number of wait states and an error response for illegal addresses. It is the responder end of the Wishbone bus driven by our master agents and checked by the master SVA checker. It also serves as the standard DUT-side slave in the SVAUnit sandbox benches.

Parameters:
NUM_REGS, 16, number of 32-bit registers; legal range 1..256.
WAIT_STATES, 2, idle cycles inserted between request sample and ACK_O/ERR_O; legal range 0..15.
BASE_ADDR, 32'h0000_0000, byte address of register 0; must be 4-byte aligned.

Ports:
CLK_I  input  1  single clock; all logic samples on the rising edge.
RST_I  input  1  asynchronous reset, active-high.
CYC_I  input  1  bus cycle in progress.
STB_I  input  1  strobe; valid transfer request when CYC_I is also high.
WE_I  input  1  1 = write, 0 = read.
ADR_I  input  32  byte address.
DAT_I  input  32  write data.
SEL_I  input  4  byte-lane enables; bit n covers DAT_I[8n+7:8n].
DAT_O  output  32  read data; valid only while ACK_O is high, 0 otherwise.
ACK_O  output  1  normal termination; one-cycle pulse.
ERR_O  output  1  error termination; one-cycle pulse; never high together with ACK_O.

Behaviour:
- Reset (async assert, released synchronously to CLK_I): FSM goes to IDLE; ACK_O=0, ERR_O=0, DAT_O=0; wait counter=0; all registers=0. Reset mid-transfer drops the transfer with no termination and no write.
- Decode: offset = ADR_I - BASE_ADDR. The address is legal iff ADR_I >= BASE_ADDR, offset[1:0]==0 and offset>>2 < NUM_REGS. index = offset>>2.
- FSM states: IDLE, WAIT, RESP.
- IDLE: if CYC_I && STB_I at an edge, latch ADR_I, WE_I, DAT_I, SEL_I and the legal flag. Go to WAIT with counter=WAIT_STATES, or go straight to RESP if WAIT_STATES==0.
- WAIT: the counter decrements each cycle. When the counter reaches 1 at an edge, go to RESP.
- RESP: ACK_O (legal) or ERR_O (illegal) is high for exactly this one cycle; the next state is IDLE unconditionally. Requests are not sampled in RESP.
- Latency: a request sampled at edge t gives ACK_O/ERR_O high during cycle t+1+WAIT_STATES.
- Write commit: on the edge entering RESP, each selected byte lane of reg[index] is updated from the latched DAT_I. Unselected lanes are kept. SEL_I=0 gives ACK with no change.
- Read: DAT_O = reg[index] (full word, SEL ignored) during RESP with ACK_O. DAT_O=0 with ERR_O.
- Illegal access: no register changes, ERR_O pulse, same latency as a legal access.
- Abort: CYC_I or STB_I low at any edge while in WAIT returns the FSM to IDLE with no write and no termination.
- Back-to-back: STB_I still high in the IDLE cycle after RESP is a new request. Minimum request spacing is WAIT_STATES+2 cycles.
- Latched request fields are used throughout WAIT and RESP, so address changes by a misbehaving master do not affect the transfer.
- Wait counter width: $clog2(WAIT_STATES+1), minimum 1 bit.

Decomposition:
- Package vgm_wb_pkg:
  - wb_state_e enum (IDLE, WAIT, RESP).
  - Constants: WB_DATA_W=32, WB_ADR_W=32, WB_SEL_W=4.
  - Function for byte-lane merge (old, new, sel).
- Sub-module vgm_wb_reg_bank: NUM_REGS x 32 storage with async reset, byte-enable write port, and combinational read port. The FSM, counter and decode stay in the top module.

Test Plan:
- Reset: RST_I pulsed for 3 cycles -> ACK_O=ERR_O=0, DAT_O=0; a read of 0x0 afterwards returns 32'h0.
- Write then read (WAIT_STATES=2): write 32'hDEAD_BEEF to 0x8 with SEL=4'hF, request sampled at t -> ACK_O high in cycle t+3 only. A read of 0x8 then returns DAT_O=32'hDEAD_BEEF with ACK.
- Byte lanes: reg 0x4 = 32'h1122_3344; write 32'hAABB_CCDD with SEL=4'b0101 -> readback 32'h11BB_33DD.
- Errors: accesses to 0x40 (NUM_REGS=16), 0x2 (misaligned) and a write to 0x44 -> ERR_O one-cycle pulse, ACK_O=0, DAT_O=0, no register modified.
- Abort and reset mid-op: drop CYC_I in the first WAIT cycle of a write to 0xC -> no ACK, reg unchanged. Assert RST_I during WAIT -> outputs 0 immediately, no termination.
- WAIT_STATES=0 with back-to-back reads, STB held -> ACK_O high every second cycle, latency 1, ACK_O never high on consecutive cycles. The master SVA checker bound alongside reports no failures.
